ras_stack: RTL and testbench
============================

Name: ras_stack

Overview:
- Return address stack storage: the responder side of the push/pop/pctoras/pcfromras interface driven by the RAS controller in the fetch path.
- Holds return addresses in a circular LIFO and presents the top entry combinationally as pcfromras.
- Acts only on a one-cycle operation strobe, because the controller holds push/pop levels between operations.
- Oldest entry is overwritten on overflow; underflow returns a sentinel.

Parameters:
- DEPTH, 8: number of 32-bit entries; power of 2, range 2..64.
- PTR_W, $clog2(DEPTH): pointer width; derived, never overridden.
- EMPTY_PC, 32'hFFFFFFFF: value driven on pcfromras when the stack is empty.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- op_valid  in  1  one-cycle strobe; push/pop/reset_in are sampled only when high.
- push  in  1  push pctoras.
- pop  in  1  pop top entry.
- reset_in  in  1  synchronous flush request from the controller; takes precedence over push/pop.
- pctoras  in  32  return address to push.
- pcfromras  out  32  current top of stack; EMPTY_PC when empty.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  PTR_W+1  valid entries, 0..DEPTH.
- overflow  out  1  one-cycle pulse: a push dropped the oldest entry.
- underflow  out  1  one-cycle pulse: a pop occurred while empty.

Behaviour:
- Storage: mem[DEPTH] x 32; tos pointer (PTR_W) indexes the top entry; count register.
- Async reset (reset_n = 0):
  - tos = DEPTH-1, count = 0, overflow = underflow = 0.
  - mem contents are don't-care; pcfromras = EMPTY_PC.
- pcfromras = (count == 0) ? EMPTY_PC : mem[tos]. Combinational: a new top is visible the cycle after the strobe edge.
- op_valid = 0: state holds; overflow/underflow = 0.
- op_valid = 1, decoded in priority order:
  1. reset_in = 1: count = 0, tos = DEPTH-1, no pulses. Same effect as async reset except memory is kept.
  2. push & !pop:
     - tos = tos+1 mod DEPTH; mem[tos+1] = pctoras.
     - count = min(count+1, DEPTH).
     - overflow = 1 if count was DEPTH; the oldest entry is silently overwritten.
  3. pop & !push:
     - If count > 0: tos = tos-1 mod DEPTH, count-1.
     - If count == 0: state unchanged, underflow = 1.
  4. push & pop (JALR pop-then-push):
     - mem[tos] = pctoras; tos and count unchanged.
     - If count == 0: mem[tos+1] = pctoras, tos+1, count = 1, underflow = 1.
  5. neither: no change.
- Pointer wrap is modulo DEPTH via natural PTR_W overflow.
- pctoras == 32'hFFFFFFFF with push = 1 is still stored; filtering is the controller's job.
- Pulses last exactly one cycle after the strobe edge.
- Reset asserted mid-sequence: all state clears immediately, independent of clk.

Optional Feature:
- Macro: RAS_STATS_EN.
- Defined:
  - Adds outputs push_cnt, pop_cnt, ovf_cnt, unf_cnt (16 bits each).
  - Each increments on the corresponding accepted event. A push&pop increments both push_cnt and pop_cnt.
  - Counters saturate at 16'hFFFF.
  - Cleared by reset_n; not cleared by reset_in.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package ras_pkg:
  - RAS_EMPTY_PC = 32'hFFFFFFFF (also used by the controller).
  - op encoding enum RAS_NOP / RAS_PUSH / RAS_POP / RAS_POPPUSH / RAS_FLUSH.
  - PC_W = 32.
- One natural sub-module, ras_mem: DEPTH x 32 register file with one write port and one async read port, no reset on the data array.
- Pointer, count and op-decode logic stay in ras_stack.

Test Plan:
- Reset, then push 0x100, 0x200, 0x300 (three strobes) -> count = 3, pcfromras = 0x300; pop -> pcfromras = 0x200, count = 2.
- DEPTH = 8: push 0x10..0x90 (9 pushes) -> overflow pulses once on the 9th, count = 8, full = 1. Then 8 pops -> pcfromras sequence 0x90, 0x80 .. 0x20, then EMPTY_PC.
- Empty stack, pop -> underflow = 1 for one cycle, count = 0, pcfromras = 32'hFFFFFFFF.
- Stack holds 0x400, 0x500; push&pop with pctoras = 0x600 -> pcfromras = 0x600, count = 2. Pop -> pcfromras = 0x400.
- Count = 5, reset_in & push strobe -> count = 0, empty = 1, no push. Async reset_n low mid-cycle -> count = 0 immediately, no clock needed.
- push = 1 with op_valid = 0 held for 10 cycles -> no state change. With RAS_STATS_EN: 3 pushes, 1 pop, 1 underflow -> push_cnt = 3, pop_cnt = 2, unf_cnt = 1.

Source files
------------

// File: rtl/ras_pkg.sv
// Shared return-address-stack definitions: PC width, empty sentinel and the
// operation encoding used by both the stack and its fetch-path controller.
package ras_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] RAS_EMPTY_PC = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    RAS_NOP,
    RAS_PUSH,
    RAS_POP,
    RAS_POPPUSH,
    RAS_FLUSH
  } ras_op_e;

endpackage

// File: rtl/ras_mem.sv
// DEPTH x PC_W register file: one synchronous write port, one asynchronous read
// port, no reset on the data array.
module ras_mem
  import ras_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [PC_W-1:0]  wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [PC_W-1:0]  rd_data
);

  logic [PC_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ras_stack.sv
// Circular return-address stack answering the RAS controller's strobed
// push/pop/flush requests. Optional event counters under RAS_STATS_EN.
module ras_stack
  import ras_pkg::*;
#(
  parameter int              DEPTH    = 8,
  parameter int              PTR_W    = $clog2(DEPTH),
  parameter logic [PC_W-1:0] EMPTY_PC = RAS_EMPTY_PC
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             op_valid,
  input  logic             push,
  input  logic             pop,
  input  logic             reset_in,
  input  logic [PC_W-1:0]  pctoras,
  output logic [PC_W-1:0]  pcfromras,
  output logic             empty,
  output logic             full,
  output logic [PTR_W:0]   count,
  output logic             overflow,
  output logic             underflow
`ifdef RAS_STATS_EN
  ,
  output logic [15:0]      push_cnt,
  output logic [15:0]      pop_cnt,
  output logic [15:0]      ovf_cnt,
  output logic [15:0]      unf_cnt
`endif
);

  localparam logic [PTR_W-1:0] TOS_INIT = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   CNT_MAX  = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);

  ras_op_e          op;
  logic [PTR_W-1:0] tos, tos_nxt, tos_inc, wr_addr;
  logic [PTR_W:0]   count_nxt;
  logic             wr_en, ovf_nxt, unf_nxt;
  logic [PC_W-1:0]  top_data;

  assign tos_inc = tos + 1'b1;
  assign empty   = (count == '0);
  assign full    = (count == CNT_MAX);

  always_comb begin
    op = RAS_NOP;
    if (op_valid) begin
      if (reset_in)          op = RAS_FLUSH;
      else if (push && !pop) op = RAS_PUSH;
      else if (pop && !push) op = RAS_POP;
      else if (push && pop)  op = RAS_POPPUSH;
    end
  end

  // Pop-then-push on a live stack rewrites the top in place; on an empty
  // stack it degrades to a plain push that also flags the missing pop.
  always_comb begin
    tos_nxt   = tos;
    count_nxt = count;
    wr_en     = 1'b0;
    wr_addr   = tos_inc;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;
    case (op)
      RAS_FLUSH: begin
        tos_nxt   = TOS_INIT;
        count_nxt = '0;
      end
      RAS_PUSH: begin
        wr_en   = 1'b1;
        tos_nxt = tos_inc;
        if (full) ovf_nxt   = 1'b1;
        else      count_nxt = count + CNT_ONE;
      end
      RAS_POP: begin
        if (empty) begin
          unf_nxt = 1'b1;
        end else begin
          tos_nxt   = tos - 1'b1;
          count_nxt = count - CNT_ONE;
        end
      end
      RAS_POPPUSH: begin
        wr_en = 1'b1;
        if (empty) begin
          tos_nxt   = tos_inc;
          count_nxt = CNT_ONE;
          unf_nxt   = 1'b1;
        end else begin
          wr_addr = tos;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tos       <= TOS_INIT;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      tos       <= tos_nxt;
      count     <= count_nxt;
      overflow  <= ovf_nxt;
      underflow <= unf_nxt;
    end
  end

  ras_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (pctoras),
    .rd_addr (tos),
    .rd_data (top_data)
  );

  assign pcfromras = empty ? EMPTY_PC : top_data;

`ifdef RAS_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  logic push_ev, pop_ev;
  assign push_ev = (op == RAS_PUSH) || (op == RAS_POPPUSH);
  assign pop_ev  = (op == RAS_POP)  || (op == RAS_POPPUSH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      push_cnt <= '0;
      pop_cnt  <= '0;
      ovf_cnt  <= '0;
      unf_cnt  <= '0;
    end else begin
      push_cnt <= sat_inc(push_cnt, push_ev);
      pop_cnt  <= sat_inc(pop_cnt, pop_ev);
      ovf_cnt  <= sat_inc(ovf_cnt, ovf_nxt);
      unf_cnt  <= sat_inc(unf_cnt, unf_nxt);
    end
  end
`endif

endmodule

// File: tb/tb_ras_stack.sv
// Directed bench for ras_stack (default DEPTH = 8, RAS_STATS_EN undefined).
module tb_ras_stack;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        push = 1'b0;
  logic        pop = 1'b0;
  logic        reset_in = 1'b0;
  logic [31:0] pctoras = '0;
  logic [31:0] pcfromras;
  logic        empty, full, overflow, underflow;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;

  always #5 clk = ~clk;

  ras_stack dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op_valid  (op_valid),
    .push      (push),
    .pop       (pop),
    .reset_in  (reset_in),
    .pctoras   (pctoras),
    .pcfromras (pcfromras),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // One strobe; returns #1 after the active edge with op_valid already low,
  // so pulses from this strobe are still visible to the caller.
  task automatic strobe(input logic p, input logic q, input logic f, input logic [31:0] pc);
    @(negedge clk);
    op_valid = 1'b1; push = p; pop = q; reset_in = f; pctoras = pc;
    @(posedge clk);
    #1;
    op_valid = 1'b0; push = 1'b0; pop = 1'b0; reset_in = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_pc", pcfromras, EMPTY);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    strobe(1, 0, 0, 32'h100);
    strobe(1, 0, 0, 32'h200);
    strobe(1, 0, 0, 32'h300);
    chk("push3_count", 32'(count), 32'd3);
    chk("push3_pc", pcfromras, 32'h300);
    strobe(0, 1, 0, 32'h0);
    chk("pop_pc", pcfromras, 32'h200);
    chk("pop_count", 32'(count), 32'd2);

    strobe(0, 0, 1, 32'h0);
    chk("flush_count", 32'(count), 32'd0);
    for (int i = 0; i < 9; i++) begin
      strobe(1, 0, 0, 32'h10 * (i + 1));
      chk($sformatf("ovf_push%0d", i), 32'(overflow), (i == 8) ? 32'd1 : 32'd0);
    end
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_full", 32'(full), 32'd1);
    idle();
    chk("ovf_clear", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_pc%0d", i), pcfromras, 32'h90 - 32'h10 * i);
      strobe(0, 1, 0, 32'h0);
    end
    chk("drain_pc_empty", pcfromras, EMPTY);
    chk("drain_empty", 32'(empty), 32'd1);

    strobe(0, 1, 0, 32'h0);
    chk("unf_pulse", 32'(underflow), 32'd1);
    chk("unf_count", 32'(count), 32'd0);
    chk("unf_pc", pcfromras, EMPTY);
    idle();
    chk("unf_clear", 32'(underflow), 32'd0);

    strobe(1, 0, 0, 32'h400);
    strobe(1, 0, 0, 32'h500);
    strobe(1, 1, 0, 32'h600);
    chk("pp_pc", pcfromras, 32'h600);
    chk("pp_count", 32'(count), 32'd2);
    chk("pp_unf", 32'(underflow), 32'd0);
    strobe(0, 1, 0, 32'h0);
    chk("pp_pop_pc", pcfromras, 32'h400);

    strobe(0, 1, 0, 32'h0);
    strobe(1, 1, 0, 32'h700);
    chk("pp_empty_unf", 32'(underflow), 32'd1);
    chk("pp_empty_count", 32'(count), 32'd1);
    chk("pp_empty_pc", pcfromras, 32'h700);

    strobe(0, 0, 1, 32'h0);
    for (int i = 0; i < 5; i++) strobe(1, 0, 0, 32'h1000 + i);
    chk("five_count", 32'(count), 32'd5);
    strobe(1, 0, 1, 32'hABC);
    chk("rin_count", 32'(count), 32'd0);
    chk("rin_empty", 32'(empty), 32'd1);
    chk("rin_pc", pcfromras, EMPTY);
    chk("rin_ovf", 32'(overflow), 32'd0);

    strobe(1, 0, 0, EMPTY);
    chk("allones_count", 32'(count), 32'd1);
    chk("allones_empty", 32'(empty), 32'd0);
    chk("allones_pc", pcfromras, EMPTY);

    strobe(1, 0, 0, 32'h2222);
    @(negedge clk);
    push = 1'b1; pctoras = 32'h3333;
    repeat (10) @(posedge clk);
    #1;
    push = 1'b0;
    chk("hold_count", 32'(count), 32'd2);
    chk("hold_pc", pcfromras, 32'h2222);

    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_count", 32'(count), 32'd0);
    chk("async_pc", pcfromras, EMPTY);
    @(negedge clk);
    reset_n = 1'b1;
    strobe(1, 0, 0, 32'h4444);
    chk("post_rst_pc", pcfromras, 32'h4444);
    chk("post_rst_count", 32'(count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
